// File: rtl/mole_round_controller.sv
// -----------------------------------------------------------------------------
// mole_round_controller
//
// Game-round sequencer for the whack-a-mole board. It owns all mole display
// timing: a fixed pause between moles, a show window that shrinks as the level
// rises, pseudo-random mole selection, hit/miss scoring and the lives count.
// All timing comes from an internal cycle counter on the system clock; no
// derived clocks are used. It sits between the debounced, edge-detected button
// logic and the LED / 7-segment display drivers.
//
// Parameters
//   NUM_MOLES       mole/button count; the mole is chosen from LFSR[1:0], so 4
//   BASE_PERIOD     show-window length in cycles at level 0
//   STEP            show-window reduction per level, in cycles
//   MIN_PERIOD      show-window floor, in cycles
//   PAUSE_CYCLES    gap between moles, in cycles
//   HITS_PER_LEVEL  hits needed for each level increment
//   LIVES           misses allowed per game (1..3)
//
// Ports
//   clock_i        system clock, all logic on the rising edge
//   reset_n_i      synchronous active-low reset
//   start_i        one-cycle pulse, starts a game from IDLE or GAMEOVER
//   buttons_i      one-cycle press pulses, bit i = mole i
//   mole_o         one-hot lit mole, 0 when none is lit
//   score_o        hit count, saturates at 255
//   level_o        current level, saturates at 15
//   lives_o        remaining lives
//   hit_pulse_o    one-cycle strobe on a counted hit
//   miss_pulse_o   one-cycle strobe on a show-window timeout
//   game_over_o    high while in GAMEOVER
// -----------------------------------------------------------------------------
module mole_round_controller #(
   parameter int NUM_MOLES      = 4,
   parameter int BASE_PERIOD    = 25000000,
   parameter int STEP           = 1000000,
   parameter int MIN_PERIOD     = 5000000,
   parameter int PAUSE_CYCLES   = 12500000,
   parameter int HITS_PER_LEVEL = 4,
   parameter int LIVES          = 3
) (
   input  logic                 clock_i,
   input  logic                 reset_n_i,
   input  logic                 start_i,
   input  logic [NUM_MOLES-1:0] buttons_i,
   output logic [NUM_MOLES-1:0] mole_o,
   output logic [7:0]           score_o,
   output logic [3:0]           level_o,
   output logic [1:0]           lives_o,
   output logic                 hit_pulse_o,
   output logic                 miss_pulse_o,
   output logic                 game_over_o
);

   // Cycle counter width: enough for BASE_PERIOD and PAUSE_CYCLES at 50 MHz.
   localparam int CNT_W = 26;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PAUSE,
      S_SHOW,
      S_OVER
   } state_e;

   // --------------------------------------------------------------------------
   // Helper functions
   // --------------------------------------------------------------------------

   // Show-window length for a level: BASE_PERIOD - level*STEP, clamped at
   // MIN_PERIOD. The comparison is done before the subtraction so the
   // difference can never wrap below zero.
   function automatic logic [CNT_W-1:0] calc_period(input logic [3:0] lvl);
      logic [31:0] red;
      red = 32'(lvl) * 32'(STEP);
      if (red >= 32'(BASE_PERIOD - MIN_PERIOD)) begin
         calc_period = CNT_W'(MIN_PERIOD);
      end else begin
         calc_period = CNT_W'(32'(BASE_PERIOD) - red);
      end
   endfunction

   function automatic logic [7:0] sat_inc_score(input logic [7:0] v);
      sat_inc_score = (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [3:0] sat_inc_level(input logic [3:0] v);
      sat_inc_level = (v == 4'hF) ? v : v + 4'd1;
   endfunction

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   state_e               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [CNT_W-1:0]     period_q;   // window length for the current level
   logic [CNT_W-1:0]     win_q;      // window length frozen at SHOW entry
   logic [15:0]          lfsr_q;
   logic [7:0]           score_q;
   logic [7:0]           hits_q;     // hits since last level increment
   logic [3:0]           level_q;
   logic [1:0]           lives_q;
   logic [NUM_MOLES-1:0] mole_q;
   logic                 hit_pulse_q;
   logic                 miss_pulse_q;
   logic                 game_over_q;

   // --------------------------------------------------------------------------
   // Next-state helpers
   // --------------------------------------------------------------------------
   logic [15:0]          lfsr_d;
   logic [CNT_W-1:0]     cnt_d;
   logic [CNT_W-1:0]     period_d;
   logic [NUM_MOLES-1:0] mole_d;
   logic                 hit_d;
   logic                 pause_done_d;
   logic                 timeout_d;
   logic                 level_up_d;

   // Fibonacci LFSR, taps 16,14,13,11: feedback enters at the top while the
   // register shifts toward bit 0.
   assign lfsr_d       = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
   assign cnt_d        = cnt_q + CNT_W'(1);
   assign period_d     = calc_period(level_q);
   assign mole_d       = NUM_MOLES'(1) << lfsr_q[1:0];
   // mole_q is only non-zero in SHOW, so a press can only hit the lit mole;
   // presses on dark positions fall out of the AND.
   assign hit_d        = (state_q == S_SHOW) && |(buttons_i & mole_q);
   assign pause_done_d = (cnt_q == CNT_W'(PAUSE_CYCLES - 1));
   assign timeout_d    = (cnt_q == (win_q - CNT_W'(1)));
   assign level_up_d   = (hits_q == 8'(HITS_PER_LEVEL - 1));

   // --------------------------------------------------------------------------
   // Round sequencer
   // --------------------------------------------------------------------------
   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         period_q     <= CNT_W'(BASE_PERIOD);
         win_q        <= CNT_W'(BASE_PERIOD);
         lfsr_q       <= 16'hACE1;
         score_q      <= '0;
         hits_q       <= '0;
         level_q      <= '0;
         lives_q      <= 2'(LIVES);
         mole_q       <= '0;
         hit_pulse_q  <= 1'b0;
         miss_pulse_q <= 1'b0;
         game_over_q  <= 1'b0;
      end else begin
         lfsr_q       <= lfsr_d;
         // Level only changes on a hit edge and PAUSE lasts several cycles,
         // so this copy is always current by the time SHOW latches it.
         period_q     <= period_d;
         hit_pulse_q  <= 1'b0;
         miss_pulse_q <= 1'b0;

         case (state_q)
            // Waiting for a game to start; GAMEOVER additionally keeps the
            // final score and level on display until the next start.
            S_IDLE, S_OVER: begin
               cnt_q  <= '0;
               mole_q <= '0;
               if (start_i) begin
                  state_q     <= S_PAUSE;
                  score_q     <= '0;
                  level_q     <= '0;
                  lives_q     <= 2'(LIVES);
                  hits_q      <= '0;
                  game_over_q <= 1'b0;
               end
            end

            S_PAUSE: begin
               mole_q <= '0;
               if (pause_done_d) begin
                  state_q <= S_SHOW;
                  cnt_q   <= '0;
                  mole_q  <= mole_d;
                  win_q   <= period_q;
               end else begin
                  cnt_q <= cnt_d;
               end
            end

            S_SHOW: begin
               // A hit takes priority over a timeout landing on the same edge.
               if (hit_d) begin
                  state_q     <= S_PAUSE;
                  cnt_q       <= '0;
                  mole_q      <= '0;
                  hit_pulse_q <= 1'b1;
                  score_q     <= sat_inc_score(score_q);
                  if (level_up_d) begin
                     hits_q  <= '0;
                     level_q <= sat_inc_level(level_q);
                  end else begin
                     hits_q <= hits_q + 8'd1;
                  end
               end else if (timeout_d) begin
                  cnt_q        <= '0;
                  mole_q       <= '0;
                  miss_pulse_q <= 1'b1;
                  lives_q      <= lives_q - 2'd1;
                  if (lives_q == 2'd1) begin
                     state_q     <= S_OVER;
                     game_over_q <= 1'b1;
                  end else begin
                     state_q <= S_PAUSE;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end

            default: begin
               state_q <= S_IDLE;
               cnt_q   <= '0;
               mole_q  <= '0;
            end
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Outputs (all driven straight from registers)
   // --------------------------------------------------------------------------
   assign mole_o       = mole_q;
   assign score_o      = score_q;
   assign level_o      = level_q;
   assign lives_o      = lives_q;
   assign hit_pulse_o  = hit_pulse_q;
   assign miss_pulse_o = miss_pulse_q;
   assign game_over_o  = game_over_q;

endmodule

// File: tb/tb_mole_round_controller.sv
// -----------------------------------------------------------------------------
// tb_mole_round_controller
//
// Bench for mole_round_controller with a shortened timing set. A game-level
// reference (score, level, lives, window length per level, mole choice from
// the LFSR sequence) predicts every observed output. Inputs change on the
// falling edge and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_mole_round_controller;

   localparam int P_BASE  = 20;
   localparam int P_STEP  = 4;
   localparam int P_MIN   = 8;
   localparam int P_PAUSE = 5;
   localparam int P_HPL   = 2;
   localparam int P_LIVES = 3;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       start   = 1'b0;
   logic [3:0] buttons = 4'b0;
   logic [3:0] mole;
   logic [7:0] score;
   logic [3:0] level;
   logic [1:0] lives;
   logic       hit_p;
   logic       miss_p;
   logic       gover;

   int total = 0;
   int bad   = 0;

   // Reference game state
   int          mscore = 0;
   int          mlevel = 0;
   int          mlives = P_LIVES;
   int          mhits  = 0;
   logic [3:0]  lit    = 4'b0;
   logic [15:0] mlfsr  = 16'hACE1;
   logic [15:0] mprev  = 16'hACE1;

   mole_round_controller #(
      .NUM_MOLES      (4),
      .BASE_PERIOD    (P_BASE),
      .STEP           (P_STEP),
      .MIN_PERIOD     (P_MIN),
      .PAUSE_CYCLES   (P_PAUSE),
      .HITS_PER_LEVEL (P_HPL),
      .LIVES          (P_LIVES)
   ) dut (
      .clock_i      (clk),
      .reset_n_i    (rst_n),
      .start_i      (start),
      .buttons_i    (buttons),
      .mole_o       (mole),
      .score_o      (score),
      .level_o      (level),
      .lives_o      (lives),
      .hit_pulse_o  (hit_p),
      .miss_pulse_o (miss_p),
      .game_over_o  (gover)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      logic b;
      b = v[0] ^ v[2] ^ v[3] ^ v[5];
      return {b, v[15:1]};
   endfunction

   function automatic int mperiod(input int lvl);
      int p;
      p = P_BASE - lvl * P_STEP;
      return (p < P_MIN) ? P_MIN : p;
   endfunction

   // Pseudo-random sequence as seen by the design: mprev holds the value in
   // effect just before the most recent clock edge.
   always @(posedge clk) begin
      if (!rst_n) begin
         mlfsr <= 16'hACE1;
      end else begin
         mprev <= mlfsr;
         mlfsr <= lfsr_next(mlfsr);
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Entered just after the edge that moved into PAUSE.
   task automatic wait_mole();
      for (int i = 1; i < P_PAUSE; i++) begin
         buttons = 4'($urandom_range(0, 15));
         start   = 1'($urandom_range(0, 1));
         tick();
         buttons = 4'b0;
         start   = 1'b0;
         chk("pause_dark", 32'({mole, hit_p, miss_p, gover}), 32'(0));
      end
      tick();
      lit = 4'b0001 << mprev[1:0];
      chk("mole_lit", 32'(mole), 32'(lit));
      chk("lit_state", 32'({score, level, lives}),
          32'({8'(mscore), 4'(mlevel), 2'(mlives)}));
   endtask

   // Entered just after the edge that lit the mole. press_at / wrong_at /
   // start_at name the show cycle on which that input is driven (-1 = never).
   task automatic play_round(input int press_at, input int wrong_at, input int start_at);
      int win;
      win = mperiod(mlevel);
      for (int k = 0; k < win; k++) begin
         buttons = 4'b0;
         start   = 1'b0;
         if (k == wrong_at) buttons = ~lit;
         if (k == start_at) start = 1'b1;
         if (k == press_at) buttons = lit;
         tick();
         buttons = 4'b0;
         start   = 1'b0;
         if (k == press_at) begin
            mscore = (mscore < 255) ? mscore + 1 : 255;
            mhits++;
            if ((mhits % P_HPL) == 0 && mlevel < 15) mlevel++;
            chk("hit_mole",   32'(mole),   32'(0));
            chk("hit_pulse",  32'(hit_p),  32'(1));
            chk("hit_nomiss", 32'(miss_p), 32'(0));
            chk("hit_score",  32'(score),  32'(mscore));
            chk("hit_level",  32'(level),  32'(mlevel));
            chk("hit_lives",  32'(lives),  32'(mlives));
            return;
         end else if (k == win - 1) begin
            mlives--;
            chk("miss_mole",  32'(mole),   32'(0));
            chk("miss_pulse", 32'(miss_p), 32'(1));
            chk("miss_nohit", 32'(hit_p),  32'(0));
            chk("miss_lives", 32'(lives),  32'(mlives));
            chk("miss_score", 32'(score),  32'(mscore));
            chk("miss_over",  32'(gover),  32'(mlives == 0));
            return;
         end else begin
            chk("show_hold", 32'({mole, hit_p, miss_p, score}),
                32'({lit, 2'b00, 8'(mscore)}));
         end
      end
   endtask

   task automatic over_restart();
      for (int i = 0; i < 6; i++) begin
         buttons = 4'($urandom_range(0, 15));
         tick();
         buttons = 4'b0;
         chk("over_hold", 32'({gover, mole, score, level, lives, hit_p, miss_p}),
             32'({1'b1, 4'b0, 8'(mscore), 4'(mlevel), 2'b00, 2'b00}));
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      mscore = 0;
      mlevel = 0;
      mlives = P_LIVES;
      mhits  = 0;
      chk("restart", 32'({gover, mole, score, level, lives}),
          32'({1'b0, 4'b0, 8'd0, 4'd0, 2'(P_LIVES)}));
      wait_mole();
   endtask

   initial begin
      int win;
      int mode;
      int press;
      int wrong;
      int st;

      // Reset state
      repeat (2) tick();
      chk("reset", 32'({mole, score, level, lives, hit_p, miss_p, gover}),
          32'({4'b0, 8'd0, 4'd0, 2'(P_LIVES), 3'b000}));
      rst_n = 1'b1;

      // IDLE ignores buttons
      for (int i = 0; i < 3; i++) begin
         buttons = 4'($urandom_range(1, 15));
         tick();
         buttons = 4'b0;
         chk("idle_dark", 32'({mole, hit_p, gover}), 32'(0));
      end

      // Start, then first mole exactly P_PAUSE edges after the start edge
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_edge", 32'({mole, gover, score, level, lives}),
          32'({4'b0, 1'b0, 8'd0, 4'd0, 2'(P_LIVES)}));
      wait_mole();

      // Untouched mole times out after the full level-0 window
      play_round(-1, -1, -1);
      wait_mole();

      // Hit on show cycle 3 after a wrong button on cycle 1
      play_round(3, 1, -1);
      wait_mole();

      // Hit on the timeout cycle wins; start during SHOW ignored
      play_round(P_BASE - 1, 2, 5);
      wait_mole();
      chk("level_after_2", 32'(level), 32'(1));

      // Six more hits, each on the last cycle of the shrinking window
      for (int i = 0; i < 6; i++) begin
         play_round(mperiod(mlevel) - 1, -1, -1);
         wait_mole();
      end
      chk("level_after_8", 32'(level), 32'(4));
      chk("score_after_8", 32'(score), 32'(8));

      // Two timeouts at the window floor end the game
      play_round(-1, -1, -1);
      wait_mole();
      play_round(-1, -1, -1);
      chk("game_over", 32'({gover, lives, score}), 32'({1'b1, 2'b00, 8'd8}));
      over_restart();

      // Randomized rounds
      for (int r = 0; r < 40; r++) begin
         win  = mperiod(mlevel);
         mode = int'($urandom_range(0, 3));
         if (mode == 0)      press = -1;
         else if (mode == 1) press = win - 1;
         else                press = int'($urandom_range(0, win - 1));
         wrong = int'($urandom_range(0, win));
         st    = int'($urandom_range(0, win));
         play_round(press, wrong, st);
         if (mlives == 0) over_restart();
         else             wait_mole();
      end

      // Make the score non-zero, then reset in the middle of a show window
      play_round(0, -1, -1);
      wait_mole();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      mscore = 0;
      mlevel = 0;
      mlives = P_LIVES;
      mhits  = 0;
      chk("midshow_reset", 32'({mole, score, level, lives, gover, hit_p, miss_p}),
          32'({4'b0, 8'd0, 4'd0, 2'(P_LIVES), 3'b000}));
      for (int i = 0; i < 8; i++) begin
         buttons = 4'($urandom_range(1, 15));
         tick();
         buttons = 4'b0;
         chk("post_reset_idle", 32'({mole, hit_p, gover}), 32'(0));
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_mole();
      play_round(1, -1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
